// File: rtl/div_freq_meter_pkg.sv
// Shared types and default widths for the divided-clock frequency meter.
package div_freq_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  localparam int DEF_N_WIN  = 16;
  localparam int DEF_N_CNT  = 16;
  localparam int DEF_N_SYNC = 2;

endpackage

// File: rtl/div_freq_meter_sync_rise_det.sv
// Synchronizes the measured clock into clk and flags its rising edges.
// prev only tracks while counting; load re-seeds it so a standing high level is not seen as an edge.
module sync_rise_det #(
  parameter int N_SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_meas,
  input  logic i_load,
  input  logic i_en,
  output logic o_rise
);

  logic [N_SYNC-1:0] r_sync;
  logic              r_prev;
  logic              w_sync_out;

  assign w_sync_out = r_sync[N_SYNC-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_SYNC-2:0], i_meas};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else if (i_load || i_en) begin
      r_prev <= w_sync_out;
    end
  end

  assign o_rise = w_sync_out & ~r_prev;

endmodule

// File: rtl/div_freq_meter.sv
// Counts rising edges of meas_in over a programmable window of clk cycles
// and hands the saturating result back through a valid/ack handshake.
module div_freq_meter
  import div_freq_meter_pkg::*;
#(
  parameter int N_WIN  = DEF_N_WIN,
  parameter int N_CNT  = DEF_N_CNT,
  parameter int N_SYNC = DEF_N_SYNC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_in,
  input  logic             start,
  input  logic [N_WIN-1:0] win_len,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [N_CNT-1:0] count,
  output logic             ovfl
);

  state_t             r_state, w_state_next;
  logic [N_WIN-1:0]   r_win_cnt, w_win_cnt_next;
  logic [N_CNT-1:0]   r_count, w_count_next;
  logic               r_ovfl, w_ovfl_next;
  logic               r_busy, r_valid;
  logic               w_rise;

  sync_rise_det #(.N_SYNC(N_SYNC)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_meas (meas_in),
    .i_load (r_state == ARM),
    .i_en   (r_state == COUNT),
    .o_rise (w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_win_cnt_next = r_win_cnt;
    w_count_next   = r_count;
    w_ovfl_next    = r_ovfl;
    case (r_state)
      IDLE, DONE: begin
        // start takes priority over ack when both arrive in DONE
        if (start) begin
          w_count_next   = '0;
          w_ovfl_next    = 1'b0;
          w_win_cnt_next = win_len;
          w_state_next   = (win_len != '0) ? ARM : DONE;
        end else if (r_state == DONE && ack) begin
          w_state_next = IDLE;
        end
      end
      ARM: begin
        w_state_next = COUNT;
      end
      COUNT: begin
        if (w_rise) begin
          if (&r_count) begin
            w_ovfl_next = 1'b1;
          end else begin
            w_count_next = r_count + N_CNT'(1);
          end
        end
        w_win_cnt_next = r_win_cnt - N_WIN'(1);
        if (r_win_cnt == N_WIN'(1)) begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_count   <= '0;
      r_ovfl    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_win_cnt <= w_win_cnt_next;
      r_count   <= w_count_next;
      r_ovfl    <= w_ovfl_next;
      r_busy    <= (w_state_next == ARM) || (w_state_next == COUNT);
      r_valid   <= (w_state_next == DONE);
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign count = r_count;
  assign ovfl  = r_ovfl;

endmodule

// File: tb/tb_div_freq_meter.sv
// Directed bench for div_freq_meter: nominal, zero window, saturation, handshake and reset cases.
module tb_div_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        meas_in;
  logic        start;
  logic        start_s;
  logic [15:0] win_len;
  logic        ack;
  logic        busy, valid, ovfl;
  logic [15:0] count;
  logic        busy_s, valid_s, ovfl_s;
  logic [3:0]  count_s;

  int n_cmp = 0;
  int n_bad = 0;
  int meas_mode = 0;
  int meas_per  = 8;
  int lat;

  always #5 clk = ~clk;

  div_freq_meter u_dut (
    .clk(clk), .rst(rst), .meas_in(meas_in), .start(start), .win_len(win_len),
    .ack(ack), .busy(busy), .valid(valid), .count(count), .ovfl(ovfl)
  );

  div_freq_meter #(.N_WIN(16), .N_CNT(4), .N_SYNC(2)) u_dut_sat (
    .clk(clk), .rst(rst), .meas_in(meas_in), .start(start_s), .win_len(win_len),
    .ack(ack), .busy(busy_s), .valid(valid_s), .count(count_s), .ovfl(ovfl_s)
  );

  // meas_in: 0 = low, 1 = high, 2 = square wave of meas_per clk cycles
  initial begin
    int ph;
    ph = 0;
    meas_in = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_mode == 0) meas_in = 1'b0;
      else if (meas_mode == 1) meas_in = 1'b1;
      else begin
        ph = (ph + 1 >= meas_per) ? 0 : ph + 1;
        meas_in = (ph < meas_per / 2);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues start (optionally with ack), optionally re-pulses start at cycle
  // start_at during the window, and returns edges from acceptance to valid.
  task automatic run(input string tag, input int w, input int start_at,
                     input logic with_ack, output int l);
    win_len = 16'(w);
    start   = 1'b1;
    ack     = with_ack;
    tick();
    start   = 1'b0;
    ack     = 1'b0;
    win_len = 16'hAAAA;
    chk({tag, ".busy0"}, busy, (w != 0));
    chk({tag, ".valid0"}, valid, (w == 0));
    l = 0;
    while (!valid && l < 300) begin
      if (l == start_at) start = 1'b1;
      tick();
      start = 1'b0;
      l++;
    end
    if (!valid) chk({tag, ".timeout"}, 32'd0, 32'd1);
    chk({tag, ".busy_done"}, busy, 1'b0);
    $display("run %s win=%0d lat=%0d count=%0d ovfl=%0d", tag, w, l, count, ovfl);
  endtask

  task automatic do_ack(input string tag, input logic [15:0] exp_cnt);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, ".valid_after_ack"}, valid, 1'b0);
    chk({tag, ".count_held"}, count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0; ack = 1'b0; win_len = '0;
    repeat (3) tick();
    chk("rst.busy", busy, 1'b0);
    chk("rst.valid", valid, 1'b0);
    chk("rst.count", count, 16'd0);
    chk("rst.ovfl", ovfl, 1'b0);
    rst = 1'b0;
    tick();

    meas_mode = 2; meas_per = 8;
    repeat (20) tick();
    run("nom", 64, -1, 1'b0, lat);
    chk("nom.lat", lat, 32'd65);
    chk("nom.count", count, 16'd8);
    chk("nom.ovfl", ovfl, 1'b0);
    do_ack("nom", 16'd8);

    // start mid-window must be ignored
    run("ign", 64, 30, 1'b0, lat);
    chk("ign.lat", lat, 32'd65);
    chk("ign.count", count, 16'd8);

    // start and ack together in DONE: start wins, new 16-cycle window
    run("sa", 16, -1, 1'b1, lat);
    chk("sa.lat", lat, 32'd17);
    chk("sa.count", count, 16'd2);
    do_ack("sa", 16'd2);

    run("zero", 0, -1, 1'b0, lat);
    chk("zero.lat", lat, 32'd0);
    chk("zero.count", count, 16'd0);
    chk("zero.ovfl", ovfl, 1'b0);
    do_ack("zero", 16'd0);

    meas_mode = 1;
    repeat (6) tick();
    run("lvl", 32, -1, 1'b0, lat);
    chk("lvl.lat", lat, 32'd33);
    chk("lvl.count", count, 16'd0);
    do_ack("lvl", 16'd0);

    meas_mode = 2; meas_per = 4;
    repeat (10) tick();
    win_len = 16'd64; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("sat.busy0", busy_s, 1'b1);
    lat = 0;
    while (!valid_s && lat < 300) begin tick(); lat++; end
    if (!valid_s) chk("sat.timeout", 32'd0, 32'd1);
    $display("run sat win=64 lat=%0d count=%0d ovfl=%0d", lat, count_s, ovfl_s);
    chk("sat.lat", lat, 32'd65);
    chk("sat.count", count_s, 4'd15);
    chk("sat.ovfl", ovfl_s, 1'b1);

    meas_mode = 2; meas_per = 8;
    repeat (10) tick();
    win_len = 16'd64; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("mid.busy", busy, 1'b1);
    chk("mid.count_nz", (count != 0), 1'b1);
    rst = 1'b1;
    #1;
    chk("mid.rst_busy", busy, 1'b0);
    chk("mid.rst_valid", valid, 1'b0);
    chk("mid.rst_count", count, 16'd0);
    chk("mid.rst_ovfl", ovfl, 1'b0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("mid.idle_valid", valid, 1'b0);
    run("post", 16, -1, 1'b0, lat);
    chk("post.lat", lat, 32'd17);
    chk("post.count", count, 16'd2);
    do_ack("post", 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
